round_input_sync: RTL and testbench

ROUND_INPUT_SYNC -- requirements
Module: round_input_sync

---
 rtl/round_input_sync_pkg.sv | 48 ++++
 rtl/round_input_sync_key_debounce.sv | 43 ++++
 rtl/round_input_sync.sv | 99 +++++++++
 tb/tb_round_input_sync.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_input_sync_pkg.sv
// rtl/round_input_sync_pkg.sv - animal encodings, scenario bit map and round FSM states
package round_input_sync_pkg;

  typedef enum logic {
    WAIT_CHOOSE = 1'b0,
    LOCKED      = 1'b1
  } round_state_t;

  localparam logic [2:0] ANIMAL_CAT     = 3'b001;
  localparam logic [2:0] ANIMAL_DOG     = 3'b010;
  localparam logic [2:0] ANIMAL_CHICKEN = 3'b100;

  // Scenario names read {p2}{p1}; catCat sits in the MSB.
  localparam int SCEN_CAT_CAT         = 8;
  localparam int SCEN_CAT_DOG         = 7;
  localparam int SCEN_CAT_CHICKEN     = 6;
  localparam int SCEN_DOG_CAT         = 5;
  localparam int SCEN_DOG_DOG         = 4;
  localparam int SCEN_DOG_CHICKEN     = 3;
  localparam int SCEN_CHICKEN_CAT     = 2;
  localparam int SCEN_CHICKEN_DOG     = 1;
  localparam int SCEN_CHICKEN_CHICKEN = 0;

  localparam logic [8:0] SCENARIO_RESET = 9'b1_0000_0000;

  function automatic logic is_animal(input logic [2:0] v);
    return (v == ANIMAL_CAT) || (v == ANIMAL_DOG) || (v == ANIMAL_CHICKEN);
  endfunction

  function automatic logic [8:0] scenario_of(input logic [2:0] p2, input logic [2:0] p1);
    logic [8:0] s;
    s = '0;
    case ({p2, p1})
      {ANIMAL_CAT,     ANIMAL_CAT}:     s[SCEN_CAT_CAT]         = 1'b1;
      {ANIMAL_CAT,     ANIMAL_DOG}:     s[SCEN_CAT_DOG]         = 1'b1;
      {ANIMAL_CAT,     ANIMAL_CHICKEN}: s[SCEN_CAT_CHICKEN]     = 1'b1;
      {ANIMAL_DOG,     ANIMAL_CAT}:     s[SCEN_DOG_CAT]         = 1'b1;
      {ANIMAL_DOG,     ANIMAL_DOG}:     s[SCEN_DOG_DOG]         = 1'b1;
      {ANIMAL_DOG,     ANIMAL_CHICKEN}: s[SCEN_DOG_CHICKEN]     = 1'b1;
      {ANIMAL_CHICKEN, ANIMAL_CAT}:     s[SCEN_CHICKEN_CAT]     = 1'b1;
      {ANIMAL_CHICKEN, ANIMAL_DOG}:     s[SCEN_CHICKEN_DOG]     = 1'b1;
      {ANIMAL_CHICKEN, ANIMAL_CHICKEN}: s[SCEN_CHICKEN_CHICKEN] = 1'b1;
      default:                          s = SCENARIO_RESET;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/round_input_sync_key_debounce.sv
// rtl/round_input_sync_key_debounce.sv - active-low key: 2-flop sync, mismatch-count debounce, press pulse
module key_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  output logic pulse
);

  logic            sync1;
  logic            sync2;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_d <= 1'b1;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      // Falling edge of the debounced level is the press; release is silent.
      pulse    <= stable_d & ~stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_input_sync.sv
// rtl/round_input_sync.sv - debounced buttons and latched player matchup for one game round
module round_input_sync
  import round_input_sync_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 19
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] key_n,
  input  logic [2:0] sw_p1,
  input  logic [2:0] sw_p2,
  output logic       cont_pulse,
  output logic       reset_game_pulse,
  output logic [8:0] scenario,
  output logic       scenario_valid,
  output logic       locked,
  output logic       choice_error
);

  logic         choose_pulse;
  logic [5:0]   sw_meta;
  logic [5:0]   sw_sync;
  logic [2:0]   p1_sync;
  logic [2:0]   p2_sync;
  round_state_t state_q;
  round_state_t state_d;
  logic [8:0]   scenario_d;
  logic         valid_d;
  logic         error_d;

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_cont (
    .clk(clk), .resetn(resetn), .raw(key_n[0]), .pulse(cont_pulse)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_choose (
    .clk(clk), .resetn(resetn), .raw(key_n[1]), .pulse(choose_pulse)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_reset_game (
    .clk(clk), .resetn(resetn), .raw(key_n[2]), .pulse(reset_game_pulse)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= {sw_p2, sw_p1};
      sw_sync <= sw_meta;
    end
  end

  assign p2_sync = sw_sync[5:3];
  assign p1_sync = sw_sync[2:0];

  // Priority reset_game > continue > choose; a lower pulse in the same cycle is dropped.
  always_comb begin
    state_d    = state_q;
    scenario_d = scenario;
    valid_d    = 1'b0;
    error_d    = choice_error;
    if (reset_game_pulse) begin
      state_d    = WAIT_CHOOSE;
      scenario_d = SCENARIO_RESET;
      error_d    = 1'b0;
    end else if (cont_pulse) begin
      if (state_q == LOCKED) begin
        state_d = WAIT_CHOOSE;
      end
    end else if (choose_pulse && (state_q == WAIT_CHOOSE)) begin
      if (is_animal(p2_sync) && is_animal(p1_sync)) begin
        scenario_d = scenario_of(p2_sync, p1_sync);
        valid_d    = 1'b1;
        error_d    = 1'b0;
        state_d    = LOCKED;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= WAIT_CHOOSE;
      scenario       <= SCENARIO_RESET;
      scenario_valid <= 1'b0;
      choice_error   <= 1'b0;
    end else begin
      state_q        <= state_d;
      scenario       <= scenario_d;
      scenario_valid <= valid_d;
      choice_error   <= error_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_round_input_sync.sv
// tb/tb_round_input_sync.sv - directed and randomized checks of round_input_sync against a window-based model
module tb_round_input_sync;

  localparam int DB  = 4;
  localparam int DBW = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] key_n;
  logic [2:0] sw_p1;
  logic [2:0] sw_p2;
  logic       cont_pulse;
  logic       reset_game_pulse;
  logic [8:0] scenario;
  logic       scenario_valid;
  logic       locked;
  logic       choice_error;

  int total = 0;
  int bad   = 0;

  round_input_sync #(.DB_CYCLES(DB), .DB_W(DBW)) dut (
    .clk(clk),
    .resetn(resetn),
    .key_n(key_n),
    .sw_p1(sw_p1),
    .sw_p2(sw_p2),
    .cont_pulse(cont_pulse),
    .reset_game_pulse(reset_game_pulse),
    .scenario(scenario),
    .scenario_valid(scenario_valid),
    .locked(locked),
    .choice_error(choice_error)
  );

  always #5 clk = ~clk;

  // Reference: a key level changes once its last DB synchronized samples all disagree with it.
  logic [DB:0] kh [3];
  logic [2:0]  m_stable;
  logic [2:0]  m_fell;
  logic [2:0]  m_pulse;
  logic [5:0]  sw_h0;
  logic [5:0]  sw_h1;
  logic [8:0]  m_scen;
  logic        m_valid;
  logic        m_locked;
  logic        m_err;

  function automatic logic window_flips(input int k);
    for (int j = 1; j <= DB; j++) begin
      if (kh[k][j] == m_stable[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int animal(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [8:0] expect_scen(input logic [2:0] p2, input logic [2:0] p1);
    return 9'd1 << (8 - 3 * animal(p2) - animal(p1));
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 3; k++) kh[k] <= '1;
      m_stable <= 3'b111;
      m_fell   <= 3'b000;
      m_pulse  <= 3'b000;
      sw_h0    <= '0;
      sw_h1    <= '0;
      m_scen   <= 9'h100;
      m_valid  <= 1'b0;
      m_locked <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        kh[k] <= {kh[k][DB-1:0], key_n[k]};
        if (window_flips(k)) m_stable[k] <= ~m_stable[k];
        m_fell[k] <= window_flips(k) && m_stable[k];
      end
      m_pulse <= m_fell;
      sw_h0   <= {sw_p2, sw_p1};
      sw_h1   <= sw_h0;
      m_valid <= 1'b0;
      if (m_pulse[2]) begin
        m_locked <= 1'b0;
        m_scen   <= 9'h100;
        m_err    <= 1'b0;
      end else if (m_pulse[0]) begin
        m_locked <= 1'b0;
      end else if (m_pulse[1] && !m_locked) begin
        if (animal(sw_h1[5:3]) >= 0 && animal(sw_h1[2:0]) >= 0) begin
          m_scen   <= expect_scen(sw_h1[5:3], sw_h1[2:0]);
          m_valid  <= 1'b1;
          m_err    <= 1'b0;
          m_locked <= 1'b1;
        end else begin
          m_err <= 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    key_n  = 3'b111;
    sw_p1  = 3'b000;
    sw_p2  = 3'b000;
    cyc(3);
    total++; if (scenario !== 9'h100) begin bad++; $display("FAIL reset_scenario actual=%b required=%b", scenario, 9'h100); end
    total++; if (scenario_valid !== 1'b0) begin bad++; $display("FAIL reset_valid actual=%b required=0", scenario_valid); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked actual=%b required=0", locked); end
    total++; if (choice_error !== 1'b0) begin bad++; $display("FAIL reset_error actual=%b required=0", choice_error); end
    total++; if ({cont_pulse, reset_game_pulse} !== 2'b00) begin bad++; $display("FAIL reset_pulses actual=%b required=00", {cont_pulse, reset_game_pulse}); end
    resetn = 1'b1;
    cyc(3);
  endtask

  task automatic test_choose_latch;
    int lat;
    sw_p2 = 3'b001;
    sw_p1 = 3'b010;
    cyc(3);
    key_n[1] = 1'b0;
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (scenario_valid) begin lat = e; break; end
    end
    total++; if (lat != DB + 4) begin bad++; $display("FAIL choose_latency actual=%0d required=%0d", lat, DB + 4); end
    total++; if (scenario !== 9'b010000000) begin bad++; $display("FAIL choose_scenario actual=%b required=%b", scenario, 9'b010000000); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL choose_locked actual=%b required=1", locked); end
    @(negedge clk);
    total++; if (scenario_valid !== 1'b0) begin bad++; $display("FAIL choose_strobe_width actual=%b required=0", scenario_valid); end
    key_n[1] = 1'b1;
    cyc(10);
  endtask

  task automatic test_glitch;
    int cnt;
    int lat;
    key_n[0] = 1'b0;
    cyc(2);
    key_n[0] = 1'b1;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (cont_pulse) cnt++; end
    total++; if (cnt != 0) begin bad++; $display("FAIL glitch_pulses actual=%0d required=0", cnt); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL glitch_locked actual=%b required=1", locked); end
    key_n[0] = 1'b0;
    cnt = 0;
    lat = 0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      if (cont_pulse) begin cnt++; if (lat == 0) lat = e; end
    end
    key_n[0] = 1'b1;
    repeat (15) begin @(negedge clk); if (cont_pulse) cnt++; end
    total++; if (cnt != 1) begin bad++; $display("FAIL hold_pulses actual=%0d required=1", cnt); end
    total++; if (lat != DB + 3) begin bad++; $display("FAIL cont_latency actual=%0d required=%0d", lat, DB + 3); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL cont_unlock actual=%b required=0", locked); end
  endtask

  task automatic test_choice_error;
    int vcnt;
    sw_p1 = 3'b011;
    sw_p2 = 3'b001;
    cyc(3);
    key_n[1] = 1'b0;
    vcnt = 0;
    repeat (12) begin @(negedge clk); if (scenario_valid) vcnt++; end
    key_n[1] = 1'b1;
    total++; if (vcnt != 0) begin bad++; $display("FAIL bad_choice_strobe actual=%0d required=0", vcnt); end
    total++; if (choice_error !== 1'b1) begin bad++; $display("FAIL bad_choice_error actual=%b required=1", choice_error); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL bad_choice_locked actual=%b required=0", locked); end
    total++; if (scenario !== 9'b010000000) begin bad++; $display("FAIL bad_choice_hold actual=%b required=%b", scenario, 9'b010000000); end
    cyc(10);
    sw_p1 = 3'b100;
    sw_p2 = 3'b100;
    cyc(3);
    key_n[1] = 1'b0;
    vcnt = 0;
    repeat (12) begin @(negedge clk); if (scenario_valid) vcnt++; end
    key_n[1] = 1'b1;
    total++; if (vcnt != 1) begin bad++; $display("FAIL good_choice_strobe actual=%0d required=1", vcnt); end
    total++; if (scenario !== 9'b000000001) begin bad++; $display("FAIL good_choice_scenario actual=%b required=%b", scenario, 9'b000000001); end
    total++; if (choice_error !== 1'b0) begin bad++; $display("FAIL good_choice_error actual=%b required=0", choice_error); end
    cyc(10);
  endtask

  task automatic test_locked_ignore;
    int vcnt;
    sw_p1 = 3'b001;
    sw_p2 = 3'b010;
    cyc(3);
    key_n[1] = 1'b0;
    vcnt = 0;
    repeat (12) begin @(negedge clk); if (scenario_valid) vcnt++; end
    key_n[1] = 1'b1;
    total++; if (vcnt != 0) begin bad++; $display("FAIL locked_strobe actual=%0d required=0", vcnt); end
    total++; if (scenario !== 9'b000000001) begin bad++; $display("FAIL locked_hold actual=%b required=%b", scenario, 9'b000000001); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL locked_stays actual=%b required=1", locked); end
    cyc(10);
    key_n[0] = 1'b0;
    cyc(12);
    key_n[0] = 1'b1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL continue_unlock actual=%b required=0", locked); end
    total++; if (scenario !== 9'b000000001) begin bad++; $display("FAIL continue_hold actual=%b required=%b", scenario, 9'b000000001); end
    cyc(10);
  endtask

  task automatic test_priority;
    int vcnt;
    int rcnt;
    key_n[2] = 1'b0;
    key_n[1] = 1'b0;
    vcnt = 0;
    rcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (scenario_valid) vcnt++;
      if (reset_game_pulse) rcnt++;
    end
    key_n[2] = 1'b1;
    key_n[1] = 1'b1;
    total++; if (vcnt != 0) begin bad++; $display("FAIL prio_strobe actual=%0d required=0", vcnt); end
    total++; if (rcnt != 1) begin bad++; $display("FAIL prio_reset_pulse actual=%0d required=1", rcnt); end
    total++; if (scenario !== 9'h100) begin bad++; $display("FAIL prio_scenario actual=%b required=%b", scenario, 9'h100); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL prio_locked actual=%b required=0", locked); end
    cyc(10);
  endtask

  task automatic test_async_reset;
    int cnt;
    int lat;
    key_n[1] = 1'b0;
    cyc(12);
    key_n[1] = 1'b1;
    cyc(10);
    total++; if (scenario !== 9'b000100000) begin bad++; $display("FAIL pre_reset_scenario actual=%b required=%b", scenario, 9'b000100000); end
    key_n[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL async_locked actual=%b required=0", locked); end
    total++; if (scenario !== 9'h100) begin bad++; $display("FAIL async_scenario actual=%b required=%b", scenario, 9'h100); end
    total++; if ({cont_pulse, reset_game_pulse, scenario_valid, choice_error} !== 4'b0000) begin
      bad++; $display("FAIL async_flags actual=%b required=0000", {cont_pulse, reset_game_pulse, scenario_valid, choice_error});
    end
    @(negedge clk);
    key_n[0] = 1'b1;
    cyc(2);
    resetn = 1'b1;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (cont_pulse) cnt++; end
    total++; if (cnt != 0) begin bad++; $display("FAIL released_no_pulse actual=%0d required=0", cnt); end
    resetn = 1'b0;
    key_n[0] = 1'b0;
    cyc(2);
    resetn = 1'b1;
    lat = 0;
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      if (cont_pulse && lat == 0) lat = e;
    end
    total++; if (lat != DB + 3) begin bad++; $display("FAIL held_through_reset actual=%0d required=%0d", lat, DB + 3); end
    key_n[0] = 1'b1;
    cyc(10);
  endtask

  task automatic test_random;
    int hold [3];
    for (int k = 0; k < 3; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total++; if (cont_pulse !== m_pulse[0]) begin bad++; $display("FAIL rnd_cont c=%0d actual=%b required=%b", c, cont_pulse, m_pulse[0]); end
      total++; if (reset_game_pulse !== m_pulse[2]) begin bad++; $display("FAIL rnd_reset_game c=%0d actual=%b required=%b", c, reset_game_pulse, m_pulse[2]); end
      total++; if (scenario !== m_scen) begin bad++; $display("FAIL rnd_scenario c=%0d actual=%b required=%b", c, scenario, m_scen); end
      total++; if (scenario_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d actual=%b required=%b", c, scenario_valid, m_valid); end
      total++; if (locked !== m_locked) begin bad++; $display("FAIL rnd_locked c=%0d actual=%b required=%b", c, locked, m_locked); end
      total++; if (choice_error !== m_err) begin bad++; $display("FAIL rnd_error c=%0d actual=%b required=%b", c, choice_error, m_err); end
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          key_n[k] = (k == 2) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 2) != 0);
          hold[k]  = $urandom_range(1, 10);
        end else begin
          hold[k]--;
        end
      end
      if ($urandom_range(0, 7) == 0)
        sw_p1 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'(1 << $urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0)
        sw_p2 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'(1 << $urandom_range(0, 2));
    end
  endtask

  initial begin
    resetn = 1'b0;
    key_n  = 3'b111;
    sw_p1  = 3'b000;
    sw_p2  = 3'b000;
    test_reset();
    test_choose_latch();
    test_glitch();
    test_choice_error();
    test_locked_ignore();
    test_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
